// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: pipelined add/subtract, one CHUNK-bit ripple per stage
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = !out_valid || out_ready)
//   a, b, cin, sub      : operands; sub=1 computes a-b as a+~b+1, ignoring cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry out (no-borrow for sub), signed overflow
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    // Stage k holds operand A with slices 0..k already replaced by their sum
    // slices, so the last stage's A register is the finished sum.
    logic             rv [STAGES];
    logic             rc [STAGES];
    logic             ro [STAGES];
    logic [WIDTH-1:0] ra [STAGES];
    logic [WIDTH-1:0] rb [STAGES];
    logic             iv [STAGES];
    logic             ic [STAGES];
    logic             nc [STAGES];
    logic             no [STAGES];
    logic [WIDTH-1:0] ia [STAGES];
    logic [WIDTH-1:0] ib [STAGES];
    logic [WIDTH-1:0] na [STAGES];
    logic [CHUNK:0]   t  [STAGES];
    logic             adv;

    assign adv       = !rv[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = rv[STAGES-1];
    assign sum       = ra[STAGES-1];
    assign cout      = rc[STAGES-1];
    assign ovf       = ro[STAGES-1];

    always_comb begin
        iv[0] = in_valid;
        ia[0] = a;
        ib[0] = sub ? ~b : b;
        ic[0] = sub ? 1'b1 : cin;
        for (int k = 1; k < STAGES; k++) begin
            iv[k] = rv[k-1];
            ia[k] = ra[k-1];
            ib[k] = rb[k-1];
            ic[k] = rc[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            t[k]  = {1'b0, ia[k][k*CHUNK +: CHUNK]} + {1'b0, ib[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, ic[k]};
            na[k] = ia[k];
            na[k][k*CHUNK +: CHUNK] = t[k][CHUNK-1:0];
            nc[k] = t[k][CHUNK];
            // carry into the slice MSB is recovered as sum ^ a ^ b at that bit
            no[k] = t[k][CHUNK] ^ t[k][CHUNK-1] ^ ia[k][k*CHUNK+CHUNK-1] ^ ib[k][k*CHUNK+CHUNK-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= 1'b0;
                rc[k] <= 1'b0;
                ro[k] <= 1'b0;
                ra[k] <= '0;
                rb[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= iv[k];
                rc[k] <= nc[k];
                ro[k] <= no[k];
                ra[k] <= na[k];
                rb[k] <= ib[k];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: randomized self-checking bench with a signed/unsigned arithmetic model
module tb_pipelined_ripple_adder;
    localparam int W = 16;
    localparam int C = 4;
    logic         clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] a = '0, b = '0, sum;
    logic [W+1:0] q[$];
    int           errors = 0, checks = 0;

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // {ovf, cout, sum} from integer arithmetic on the signed and unsigned readings
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        int  sx, sy, ux, uy, r;
        logic c, o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        if (sb) begin
            r = sx - sy;
            c = ux >= uy;
        end else begin
            r = sx + sy + int'(ci);
            c = (ux + uy + int'(ci)) > 65535;
        end
        o = (r > 32767) || (r < -32768);
        return {o, c, W'(r)};
    endfunction

    task automatic rand_beat();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_vector(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic sb,
                               input logic [W-1:0] es, input logic ec, input logic eo);
        out_ready = 1;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_latency%0d: got out_valid=%b want 0", name, i, out_valid); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
        checks++; if (sum !== es) begin errors++; $display("FAIL %s_sum: got %h want %h", name, sum, es); end
        checks++; if (cout !== ec) begin errors++; $display("FAIL %s_cout: got %b want %b", name, cout, ec); end
        checks++; if (ovf !== eo) begin errors++; $display("FAIL %s_ovf: got %b want %b", name, ovf, eo); end
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        int first = -1, last = -1, n_out = 0;
        logic [W+1:0] want;
        out_ready = 1;
        for (int cyc = 0; cyc < 140 && (cyc < 100 || q.size() > 0); cyc++) begin
            in_valid = cyc < 100;
            if (in_valid) rand_beat();
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_out++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got result %h with nothing outstanding", sum);
                end else begin
                    want = q.pop_front();
                    if ({ovf, cout, sum} !== want) begin
                        errors++; $display("FAIL stream_data: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                           ovf, cout, sum, want[W+1], want[W], want[W-1:0]);
                    end
                end
            end
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1", in_ready); end
                if (in_ready) q.push_back(model(a, b, cin, sub));
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        checks++; if (first !== 4) begin errors++; $display("FAIL stream_first: got cycle %0d want 4", first); end
        checks++; if (last !== 103) begin errors++; $display("FAIL stream_last: got cycle %0d want 103", last); end
        checks++; if (n_out !== 100) begin errors++; $display("FAIL stream_count: got %0d want 100", n_out); end
    endtask

    task automatic test_backpressure();
        int n_in = 0, n_out = 0;
        logic hv = 0;
        logic [W+1:0] held, want;
        for (int cyc = 0; cyc < 80 && (cyc < 30 || q.size() > 0); cyc++) begin
            in_valid  = cyc < 30;
            out_ready = !(cyc >= 10 && cyc < 15);
            if (in_valid) rand_beat();
            @(negedge clk);
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                if (hv) begin
                    checks++;
                    if ({ovf, cout, sum} !== held) begin errors++; $display("FAIL bp_stable: got %h want %h", {ovf, cout, sum}, held); end
                end
                held = {ovf, cout, sum};
                hv = 1;
            end else hv = 0;
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got result %h with nothing outstanding", sum);
                end else begin
                    want = q.pop_front();
                    if ({ovf, cout, sum} !== want) begin errors++; $display("FAIL bp_data: got %h want %h", {ovf, cout, sum}, want); end
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                q.push_back(model(a, b, cin, sub));
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        checks++; if (n_out !== n_in) begin errors++; $display("FAIL bp_count: got %0d outputs want %0d", n_out, n_in); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_drain: got %0d outstanding want 0", q.size()); end
    endtask

    task automatic test_random_flow();
        logic [W+1:0] want;
        for (int cyc = 0; cyc < 260 && (cyc < 200 || q.size() > 0); cyc++) begin
            in_valid  = cyc < 200 ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = cyc < 200 ? ($urandom_range(0, 3) != 0) : 1'b1;
            rand_beat();
            @(negedge clk);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL flow_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL flow_extra: got result %h with nothing outstanding", sum);
                end else begin
                    want = q.pop_front();
                    if ({ovf, cout, sum} !== want) begin errors++; $display("FAIL flow_data: got %h want %h", {ovf, cout, sum}, want); end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL flow_drain: got %0d outstanding want 0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 0;
        cin = 0; sub = 0; b = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1;
            a = 16'h1111 + W'(i);
            @(posedge clk); #1;
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        checks++; if (sum !== 16'h1112) begin errors++; $display("FAIL mid_pre_sum: got %h want 1112", sum); end
        #2 rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL mid_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_flags: got cout=%b ovf=%b want 0 0", cout, ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got out_valid=%b sum=%h want no result", i, out_valid, sum); end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_vector("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_vector("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_vector("ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        test_vector("cin_add",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        test_vector("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_vector("sub_ok",    16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
        test_streaming();
        test_backpressure();
        test_random_flow();
        test_reset_midflight();
        test_vector("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined add/subtract unit with ripple carries. The operand is split into CHUNK-bit slices, and each pipeline stage ripples one slice while carrying the result forward in registers. It gives full throughput (one operation per cycle) at WIDTH/CHUNK cycles of latency. A valid/ready handshake on both sides lets it sit between registered datapath blocks in the arithmetic library.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits rippled per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry in (ignored when sub=1).
- sub  input  1  0: A+B+cin; 1: A−B (computed as A+~B+1).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational). A beat is accepted when in_valid && in_ready.
- Stage 0 captures a, (sub ? ~b : b), carry = (sub ? 1 : cin) and valid, then adds slice 0.
- Stage k (1..STAGES−1) adds slice k using the stage k−1 carry register. Upper, unprocessed operand slices and completed lower sum slices travel with the beat in skew registers.
- Final stage registers drive sum, cout, ovf and out_valid. ovf uses the carry into bit WIDTH−1 from the last slice's internal ripple.
- On adv=0 all stages hold, including valid bits; no beat is lost or duplicated. Bubbles propagate as valid=0 stages. Data in invalid stages is don't-care, but outputs only change when adv=1.
- Arithmetic is modulo 2^WIDTH. cout and ovf are both provided; the consumer chooses the signed or unsigned interpretation.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Timing
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 immediately after reset since out_valid=0.
- Latency: a beat accepted at edge n presents out_valid=1 with its result after edge n+STAGES−1, i.e. visible STAGES cycles after in_valid/in_ready are sampled high. WIDTH=16, CHUNK=4 gives 4 cycles.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_valid=1 && out_ready=0 deasserts in_ready in the same cycle, and sum/cout/ovf stay stable until the handshake completes.
- Simultaneous events: out_ready=1 with a new accept in the same cycle is legal, and the pipeline shifts by one.
- Reset mid-operation flushes all in-flight beats with no output produced, and the unit returns to the reset state.
- Critical path is one CHUNK-bit ripple plus the stage mux.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Carry through all stages: a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> 4 cycles later sum=16'h0000, cout=1, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1; a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
- Subtract: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0 (borrow), ovf=0; a=16'h1234, b=16'h0234 -> sum=16'h1000, cout=1.
- Streaming: 100 back-to-back random beats with out_ready=1 -> results match a reference model in order, one per cycle, first at cycle 4.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream with in_valid=1 -> in_ready=0 while out_valid=1, output stable, and the sequence complete with no drop or duplicate after release.
- Reset mid-flight: assert rst with 3 beats in flight -> out_valid=0 and sum=0 immediately, and no stale results appear after release.
